freq_gen_dds: RTL
=================

# freq_gen_dds

Programmable square-wave generator, the transmit-side counterpart of the direct-count frequency meter. Accepts a target frequency in Hz over a valid/ready handshake, converts it to a phase-accumulator tuning word with a sequential divider, and drives a square wave derived from the accumulator. New frequencies take effect glitch-free at an accumulator wrap. Used as an on-board stimulus source and as a loopback source for frequency measurement.

## Interface
- CLK_HZ, 100_000_000: frequency of clk in Hz.
- ACC_W, 32: phase accumulator and tuning word width.
- FRE_W, 32: width of frequency request and echo.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- fre_in  in  FRE_W  requested output frequency in Hz.
- fre_valid  in  1  request valid; accepted on a clk edge with fre_ready high.
- fre_ready  out  1  block can accept a new request.
- clk_out  out  1  generated square wave, registered.
- fre_cur  out  FRE_W  frequency (Hz, after saturation) of the tuning word currently applied.
- sat  out  1  high when the last accepted request was clamped.
- duty  in  8  high-time fraction, duty/256. Present only with DUTY_CTRL_EN.

## Operation
- FSM states: IDLE, CALC, PEND.
- IDLE: fre_ready=1. On fre_valid&&fre_ready, latch f = min(fre_in, CLK_HZ/2). Set sat = (fre_in > CLK_HZ/2). Go to CALC.
- CALC: restoring division computing TW = floor(f * 2^ACC_W / CLK_HZ).
  - Remainder r starts at f.
  - Each cycle: r = r<<1; if r >= CLK_HZ then r -= CLK_HZ and the next quotient bit is 1, else 0. Bits are produced MSB first.
  - r is ceil(log2(CLK_HZ))+1 bits wide.
  - Exactly ACC_W cycles, then go to PEND.
- PEND: hold the computed TW as tw_next.
  - If the applied tw == 0, apply next cycle.
  - Otherwise apply on the cycle following an accumulator carry-out (acc + tw >= 2^ACC_W).
  - On apply: tw <= tw_next, fre_cur <= f, go to IDLE.
- Accumulator: acc <= acc + tw (mod 2^ACC_W) every cycle. It is not cleared on a frequency change, so phase is continuous.
- clk_out <= acc[ACC_W-1], registered, so 50% duty.
- f = 0 gives tw = 0: acc freezes and clk_out holds its current level.
- fre_valid while fre_ready = 0 is ignored, not queued. The requester must hold fre_valid until the handshake.

## Timing
- Reset values: acc=0, tw=0, tw_next=0, clk_out=0, fre_cur=0, sat=0, state IDLE, fre_ready=1.
- Reset asserted mid-CALC or mid-PEND: the request is discarded and all outputs return to reset values immediately.
- Accept at edge k: fre_ready=0 from k until the apply edge. sat is valid from k+1.
- CALC occupies edges k+1..k+ACC_W.
- Apply with tw==0: edge k+ACC_W+1.
- Apply with tw!=0: the edge after the first carry-out at or after k+ACC_W+1.
- fre_ready returns to 1 on the apply edge, so a new request can be accepted the following edge.
- The first accumulator update with the new tw occurs on the edge after apply.
- clk_out lags acc MSB by one cycle.
- Output frequency = tw * CLK_HZ / 2^ACC_W. Error is below CLK_HZ/2^ACC_W Hz because of truncation.
- Carry-out coincident with PEND entry (edge k+ACC_W) does not apply; only carries from k+ACC_W+1 onward count.

## Configuration
- DUTY_CTRL_EN defined:
  - Adds the duty port.
  - clk_out <= (acc[ACC_W-1 -: 8] < duty).
  - duty=0 gives constant 0; duty=128 gives 50%.
  - duty is sampled every cycle and is not handshaked.
- DUTY_CTRL_EN undefined:
  - No duty port.
  - clk_out <= acc[ACC_W-1].

## Test plan
All scenarios use default parameters.
- fre_in=25_000_000: fre_ready low 33 cycles (apply immediate, since tw was 0). tw=0x4000_0000. clk_out period exactly 4 clk, 2 high/2 low. fre_cur=25_000_000, sat=0.
- fre_in=1_000_000: tw=42_949_672. Average clk_out period 100 clk over 10_000 clk, within ±1 edge.
- fre_in=60_000_000: sat=1, fre_cur=50_000_000, tw=0x8000_0000, clk_out toggles every clk.
- Running at 1 MHz, request 2 MHz: tw updates only on the edge after an accumulator carry-out. No clk_out high or low pulse shorter than 25 clk. fre_ready rises on the apply edge.
- Assert rst_n low at CALC cycle 10: clk_out=0, fre_cur=0, fre_ready=1 immediately. A request after release completes normally.
- With DUTY_CTRL_EN, fre_in=25_000_000: duty=64 gives clk_out high 1 of 4 clk; duty=0 gives clk_out constant 0.

Source files
------------

// File: rtl/freq_gen_dds.sv
// freq_gen_dds: phase-accumulator square-wave generator with a sequential Hz-to-tuning-word divider.
// Optional DUTY_CTRL_EN adds an 8-bit duty input controlling clk_out high time.
module freq_gen_dds #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int          ACC_W  = 32,
   parameter int          FRE_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [FRE_W-1:0] fre_in,
   input  logic             fre_valid,
   output logic             fre_ready,
   output logic             clk_out,
   output logic [FRE_W-1:0] fre_cur,
   output logic             sat
`ifdef DUTY_CTRL_EN
   ,
   input  logic [7:0]       duty
`endif
);

   localparam int R_W = $clog2(CLK_HZ) + 1;
   localparam int C_W = $clog2(ACC_W + 1);
   localparam logic [FRE_W-1:0] F_MAX = FRE_W'(CLK_HZ / 2);
   localparam logic [R_W:0] C_R = (R_W + 1)'(CLK_HZ);
   localparam logic [C_W-1:0] LAST = C_W'(ACC_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      PEND
   } state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] tw;
   logic [ACC_W-1:0] tw_next;
   logic [FRE_W-1:0] f;
   logic [R_W-1:0]   r;
   logic [C_W-1:0]   cnt;
   logic             wrap_seen;

   logic [ACC_W:0]   sum;
   logic             carry;
   logic [R_W:0]     r2;
   logic             r_ge;
   logic             sat_req;
   logic [FRE_W-1:0] f_sat;

   assign sum     = {1'b0, acc} + {1'b0, tw};
   assign carry   = sum[ACC_W];
   assign r2      = {r, 1'b0};
   assign r_ge    = (r2 >= C_R);
   assign sat_req = (fre_in > F_MAX);
   assign f_sat   = sat_req ? F_MAX : fre_in;

   // Request handshake, restoring divider and wrap-aligned tuning word swap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fre_ready <= 1'b1;
         sat       <= 1'b0;
         f         <= '0;
         r         <= '0;
         cnt       <= '0;
         tw_next   <= '0;
         tw        <= '0;
         fre_cur   <= '0;
         wrap_seen <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (fre_valid && fre_ready) begin
                  f         <= f_sat;
                  sat       <= sat_req;
                  r         <= R_W'(f_sat);
                  cnt       <= '0;
                  tw_next   <= '0;
                  fre_ready <= 1'b0;
                  state     <= CALC;
               end
            end
            CALC: begin
               r       <= r_ge ? R_W'(r2 - C_R) : R_W'(r2);
               tw_next <= {tw_next[ACC_W-2:0], r_ge};
               cnt     <= cnt + 1'b1;
               if (cnt == LAST) begin
                  wrap_seen <= 1'b0;
                  state     <= PEND;
               end
            end
            PEND: begin
               if ((tw == '0) || wrap_seen) begin
                  tw        <= tw_next;
                  fre_cur   <= f;
                  fre_ready <= 1'b1;
                  wrap_seen <= 1'b0;
                  state     <= IDLE;
               end else if (carry) begin
                  wrap_seen <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               fre_ready <= 1'b1;
            end
         endcase
      end
   end

   // Free-running phase accumulator and registered square-wave output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         clk_out <= 1'b0;
      end else begin
         acc <= sum[ACC_W-1:0];
`ifdef DUTY_CTRL_EN
         clk_out <= (acc[ACC_W-1 -: 8] < duty);
`else
         clk_out <= acc[ACC_W-1];
`endif
      end
   end

endmodule
